// File: rtl/bbox_msg_reader_if.sv
// -----------------------------------------------------------------------------
// bbox_msg_reader_if
//   Avalon-MM link between bbox_msg_reader (master) and the image-processor
//   message slave.
//
// Handshake: Avalon-MM with no waitrequest. A read is one cycle with
//   m_chipselect=1 and m_read=1. The slave presents m_readdata exactly one
//   cycle later, and the master samples it in that cycle. A write is one cycle
//   with m_chipselect=1 and m_write=1, and it is always accepted in that cycle.
//   The slave pops one word for each read, so reads are never back to back.
//
// Signals
//   m_chipselect  master -> slave  chip select
//   m_read        master -> slave  read strobe
//   m_write       master -> slave  write strobe
//   m_address     master -> slave  word address (0 = status, 1 = message)
//   m_writedata   master -> slave  write data
//   m_readdata    slave -> master  read data, valid the cycle after m_read
// -----------------------------------------------------------------------------
interface bbox_msg_reader_if;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_chipselect,
    output m_read,
    output m_write,
    output m_address,
    output m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_chipselect,
    input  m_read,
    input  m_write,
    input  m_address,
    input  m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/bbox_msg_reader.sv
// -----------------------------------------------------------------------------
// bbox_msg_reader
//   Polls an image-processor slave for bounding-box messages. A message is
//   three words: the ID word, then {left,top}, then {right,bottom}. Each
//   coordinate is 11 bits, placed at [26:16] and [10:0].
//
//   While idle, the block waits POLL_CYCLES cycles and then reads the status
//   word. If the status word reports at least 3 queued words, the block reads
//   the ID word and the two coordinate words, and then publishes the box.
//
// Configuration macro
//   BBOX_RESYNC_FLUSH_EN  When defined, a bad ID word is followed by a single
//                         write of 0x10 to address 0, which asks the slave to
//                         flush its queue. When undefined, only the bad word is
//                         dropped, and the block waits for the next poll.
//
// Parameters
//   POLL_CYCLES  idle cycles between status polls
//   MSG_ID       required value of the first message word
//
// Ports
//   clk, reset   clock and asynchronous active-high reset
//   enable       polling permitted
//   avm          Avalon-MM master port (bbox_msg_reader_if.master)
//   bb_left/top/right/bottom  last decoded box
//   bb_found     the last box is non-empty (left<=right and top<=bottom)
//   bb_valid     one-cycle pulse when the bb_* outputs change
//   sync_err     one-cycle pulse after a bad ID word
//   msg_count    decoded message count, wraps at 16 bits
//   dbg_state    current FSM state
// -----------------------------------------------------------------------------
module bbox_msg_reader #(
  parameter int          POLL_CYCLES = 1024,
  parameter logic [31:0] MSG_ID      = 32'h00524242
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  bbox_msg_reader_if.master        avm,
  output logic [10:0]              bb_left,
  output logic [10:0]              bb_top,
  output logic [10:0]              bb_right,
  output logic [10:0]              bb_bottom,
  output logic                     bb_found,
  output logic                     bb_valid,
  output logic                     sync_err,
  output logic [15:0]              msg_count,
  output logic [3:0]               dbg_state
);

  localparam int            CW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    RD_STAT,
    CAP_STAT,
    RD_ID,
    CAP_ID,
    RD_TL,
    CAP_TL,
    RD_BR,
    CAP_BR,
    PUBLISH
`ifdef BBOX_RESYNC_FLUSH_EN
    ,
    FLUSH
`endif
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] poll_cnt;
  logic [10:0]   cap_left;
  logic [10:0]   cap_top;

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // The poll counter runs only in IDLE while enable is high. It is held at 0
  // in every other case, so each visit to IDLE starts a full poll interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (state == IDLE && enable && poll_cnt != POLL_LAST) begin
      poll_cnt <= poll_cnt + 1'b1;
    end else begin
      poll_cnt <= '0;
    end
  end

  // Next-state logic and bus strobes. The strobes are decoded from the state
  // register, so an asynchronous reset removes them at once.
  always_comb begin
    state_n          = state;
    avm.m_chipselect = 1'b0;
    avm.m_read       = 1'b0;
    avm.m_write      = 1'b0;
    avm.m_address    = 3'd0;
    avm.m_writedata  = 32'd0;
    case (state)
      IDLE: begin
        if (enable && poll_cnt == POLL_LAST) state_n = RD_STAT;
      end
      RD_STAT: begin
        avm.m_chipselect = 1'b1;
        avm.m_read       = 1'b1;
        state_n          = CAP_STAT;
      end
      CAP_STAT: begin
        state_n = (avm.m_readdata[15:8] >= 8'd3) ? RD_ID : IDLE;
      end
      RD_ID: begin
        avm.m_chipselect = 1'b1;
        avm.m_read       = 1'b1;
        avm.m_address    = 3'd1;
        state_n          = CAP_ID;
      end
      CAP_ID: begin
        if (avm.m_readdata == MSG_ID) begin
          state_n = RD_TL;
        end else begin
`ifdef BBOX_RESYNC_FLUSH_EN
          state_n = FLUSH;
`else
          state_n = IDLE;
`endif
        end
      end
      RD_TL: begin
        avm.m_chipselect = 1'b1;
        avm.m_read       = 1'b1;
        avm.m_address    = 3'd1;
        state_n          = CAP_TL;
      end
      CAP_TL:  state_n = RD_BR;
      RD_BR: begin
        avm.m_chipselect = 1'b1;
        avm.m_read       = 1'b1;
        avm.m_address    = 3'd1;
        state_n          = CAP_BR;
      end
      CAP_BR:  state_n = PUBLISH;
      PUBLISH: state_n = IDLE;
`ifdef BBOX_RESYNC_FLUSH_EN
      FLUSH: begin
        avm.m_chipselect = 1'b1;
        avm.m_write      = 1'b1;
        avm.m_address    = 3'd0;
        avm.m_writedata  = 32'h0000_0010;
        state_n          = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Datapath. The box registers are loaded on the clock edge that enters
  // PUBLISH. In the PUBLISH cycle, the new coordinates, bb_found and the
  // bb_valid pulse all appear together, 8 cycles after RD_STAT. Right and
  // bottom come straight from the CAP_BR read data, so a message cut short by
  // reset never reaches the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_left  <= '0;
      cap_top   <= '0;
      bb_left   <= '0;
      bb_top    <= '0;
      bb_right  <= '0;
      bb_bottom <= '0;
      bb_found  <= 1'b0;
      bb_valid  <= 1'b0;
      sync_err  <= 1'b0;
      msg_count <= '0;
    end else begin
      bb_valid <= 1'b0;
      sync_err <= 1'b0;
      if (state == CAP_ID && avm.m_readdata != MSG_ID) begin
        sync_err <= 1'b1;
      end
      if (state == CAP_TL) begin
        cap_left <= avm.m_readdata[26:16];
        cap_top  <= avm.m_readdata[10:0];
      end
      if (state == CAP_BR) begin
        bb_left   <= cap_left;
        bb_top    <= cap_top;
        bb_right  <= avm.m_readdata[26:16];
        bb_bottom <= avm.m_readdata[10:0];
        bb_found  <= (cap_left <= avm.m_readdata[26:16]) &&
                     (cap_top  <= avm.m_readdata[10:0]);
        bb_valid  <= 1'b1;
        msg_count <= msg_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/bbox_msg_reader.md
BBOX_MSG_READER -- requirements
Module: bbox_msg_reader

Interface
REQ-001 Parameter POLL_CYCLES, default 1024: clk cycles between status polls while idle.
REQ-002 Parameter MSG_ID, default 32'h00524242 ("RBB"): required value of the first word of every message.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = polling permitted.
REQ-006 m_chipselect  output  1  Avalon-MM master chip select to the image-processor slave.
REQ-007 m_read  output  1  read strobe.
REQ-008 m_write  output  1  write strobe.
REQ-009 m_address  output  3  word address: 0 = status, 1 = message.
REQ-010 m_writedata  output  32  write data.
REQ-011 m_readdata  input  32  slave read data, valid the cycle after m_read.
REQ-012 bb_left, bb_top, bb_right, bb_bottom  output  11 each  last decoded box.
REQ-013 bb_found  output  1  last decoded box is non-empty.
REQ-014 bb_valid  output  1  one-cycle pulse when the bb_* outputs update.
REQ-015 sync_err  output  1  one-cycle pulse when the ID word is bad.
REQ-016 msg_count  output  16  count of decoded messages; wraps at 65535 -> 0.

Function
REQ-017 The FSM SHALL have these states: IDLE, RD_STAT, CAP_STAT, RD_ID, CAP_ID, RD_TL, CAP_TL, RD_BR, CAP_BR, PUBLISH, and FLUSH (FLUSH is present only when the macro in REQ-033 is defined).
REQ-018 IDLE SHALL count POLL_CYCLES cycles, then go to RD_STAT when enable=1; while enable=0 the counter SHALL hold at 0.
REQ-019 Each RD_* state SHALL last exactly one cycle with m_chipselect=1 and m_read=1, and m_address = 0 for RD_STAT or 1 otherwise; every other state SHALL drive m_read=0.
REQ-020 Each CAP_* state SHALL register m_readdata, so read latency is fixed at 1 and there is no waitrequest.
REQ-021 At least one m_read=0 cycle SHALL separate consecutive reads, so the slave pops exactly one word per read.
REQ-022 CAP_STAT: word count = m_readdata[15:8]; next state is RD_ID if the count is 3 or more, else IDLE.
REQ-023 CAP_ID: if m_readdata equals MSG_ID, next state is RD_TL; otherwise pulse sync_err and take the resync path in REQ-033.
REQ-024 CAP_TL SHALL capture left = m_readdata[26:16] and top = m_readdata[10:0]; CAP_BR SHALL capture right = [26:16] and bottom = [10:0]; bits [31:27] and [15:11] are ignored.
REQ-025 PUBLISH SHALL update bb_left, bb_top, bb_right and bb_bottom together, pulse bb_valid for one cycle, increment msg_count, and return to IDLE with the poll counter cleared.
REQ-026 bb_found SHALL be 1 iff left <= right and top <= bottom (unsigned); the empty-frame message (639,479)/(0,0) yields bb_found=0, with the coordinates still published.
REQ-027 bb_* outputs SHALL hold between PUBLISH events; a sync_err SHALL NOT alter them.
REQ-028 Latency: bb_valid SHALL assert exactly 8 cycles after the RD_STAT cycle for a valid message.
REQ-029 enable falling mid-message SHALL NOT abort it: the message completes and the FSM then idles.
REQ-030 m_write SHALL be 0 outside FLUSH; m_writedata SHALL be 0 outside FLUSH.

Reset
REQ-031 While reset=1 the block SHALL asynchronously force state IDLE, poll counter 0, all m_* outputs 0, bb_* outputs 0, bb_found 0, bb_valid 0, sync_err 0, msg_count 0.
REQ-032 Reset asserted mid-transaction SHALL drop m_read and m_write immediately, and partial captures SHALL be discarded.

Configuration
REQ-033 Macro BBOX_RESYNC_FLUSH_EN: defined -> after a bad ID, the FSM SHALL enter FLUSH for one cycle (m_chipselect=1, m_write=1, m_address=0, m_writedata=32'h00000010), then go to IDLE; undefined -> the FSM SHALL go straight to IDLE with no write, discarding only the bad word, and re-poll.

Verification
REQ-034 Status words=3, then message words "RBB", {x=100,y=50}, {x=200,y=150} -> bb=(100,50,200,150), bb_found=1, bb_valid 8 cycles after RD_STAT, msg_count=1.
REQ-035 Status words=2 -> no RD_ID read, FSM back to IDLE, bb_* unchanged.
REQ-036 Message (639,479)/(0,0) -> bb_valid pulse, bb_found=0, coordinates published as given.
REQ-037 ID word 32'h12345678 -> sync_err pulse; with the macro, one write of 0x10 to address 0; without it, no write and the next poll comes after POLL_CYCLES.
REQ-038 reset asserted during RD_TL -> m_read=0 in the same cycle, all outputs 0, polling resumes after release.
REQ-039 Back-to-back reads checked: no two adjacent cycles have m_read=1; msg_count wraps 65535 -> 0 when preloaded by 65535 messages.
